om_scan: RTL and testbench

OM_SCAN -- requirements
Module: om_scan

---
 rtl/om_scan.sv | 177 +++++++++++++++++
 tb/tb_om_scan.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/om_scan.sv
`default_nettype none
// ---------------------------------------------------------------------------
// om_scan : sweeps the three OM score maps, emits above-threshold detections
//           and clears every visited word behind the scan.
// Revision : 1.0
// ---------------------------------------------------------------------------
module om_scan #(
  parameter logic [12:0] LAST_23 = 13'd3599,
  parameter logic [12:0] LAST_19 = 13'd3919,
  parameter logic [12:0] LAST_17 = 13'd4151,
  parameter int          RD_LAT  = 2
) (
  input  logic        iClk,
  input  logic        iReset_n,
  input  logic        iStart,
  input  logic [31:0] iThreshold,
  input  logic [31:0] iData_from_OM_23x23,
  input  logic [31:0] iData_from_OM_19x19,
  input  logic [31:0] iData_from_OM_17x17,
  input  logic        iReady,
  output logic        oRun_PostP,
  output logic [12:0] oAddr_PostP_OM_23x23,
  output logic [12:0] oAddr_PostP_OM_19x19,
  output logic [12:0] oAddr_PostP_OM_17x17,
  output logic        oWrreq_PostP_OM_23x23,
  output logic        oWrreq_PostP_OM_19x19,
  output logic        oWrreq_PostP_OM_17x17,
  output logic [31:0] oZr_to_OM_23x23,
  output logic [31:0] oZr_to_OM_19x19,
  output logic [31:0] oZr_to_OM_17x17,
  output logic        oValid,
  output logic [1:0]  oScale,
  output logic [12:0] oAddr_Hit,
  output logic [31:0] oScore,
  output logic        oBusy,
  output logic        oDone
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WAIT = 3'd2,
    S_EMIT = 3'd3,
    S_CLR  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [7:0] c_rdLat = 8'(RD_LAT);

  state_t             r_state;
  state_t             w_nextState;
  logic [12:0]        r_addr;
  logic signed [31:0] r_thr;
  logic [31:0]        r_q23;
  logic [31:0]        r_q19;
  logic [31:0]        r_q17;
  logic [2:0]         r_pend;
  logic [7:0]         r_waitCnt;

  logic [2:0]  w_hit;
  logic [2:0]  w_sel;
  logic [1:0]  w_recScale;
  logic [31:0] w_recScore;
  logic        w_recValid;
  logic        w_handshake;
  logic        w_waitDone;
  logic        w_busy;

  // Scale order in r_pend: bit0 = 23x23, bit1 = 19x19, bit2 = 17x17.
  always_comb begin
    w_hit[0] = (r_addr <= LAST_23) && ($signed(iData_from_OM_23x23) > r_thr);
    w_hit[1] = (r_addr <= LAST_19) && ($signed(iData_from_OM_19x19) > r_thr);
    w_hit[2] = (r_addr <= LAST_17) && ($signed(iData_from_OM_17x17) > r_thr);
  end

  always_comb begin
    w_sel      = 3'b000;
    w_recScale = 2'd0;
    w_recScore = 32'd0;
    if (r_pend[0]) begin
      w_sel      = 3'b001;
      w_recScale = 2'd0;
      w_recScore = r_q23;
    end else if (r_pend[1]) begin
      w_sel      = 3'b010;
      w_recScale = 2'd1;
      w_recScore = r_q19;
    end else if (r_pend[2]) begin
      w_sel      = 3'b100;
      w_recScale = 2'd2;
      w_recScore = r_q17;
    end
  end

  assign w_recValid  = (r_state == S_EMIT) && (r_pend != 3'b000);
  assign w_handshake = w_recValid && iReady;
  assign w_waitDone  = (r_waitCnt >= c_rdLat);
  assign w_busy      = (r_state == S_RD) || (r_state == S_WAIT) ||
                       (r_state == S_EMIT) || (r_state == S_CLR);

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: if (iStart) w_nextState = S_RD;
      S_RD:   w_nextState = S_WAIT;
      S_WAIT: if (w_waitDone) w_nextState = S_EMIT;
      S_EMIT: begin
        if (r_pend == 3'b000)
          w_nextState = S_CLR;
        else if (w_handshake && ((r_pend & ~w_sel) == 3'b000))
          w_nextState = S_CLR;
      end
      S_CLR:  w_nextState = (r_addr == LAST_17) ? S_DONE : S_RD;
      S_DONE: w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      r_state   <= S_IDLE;
      r_addr    <= 13'd0;
      r_thr     <= 32'sd0;
      r_q23     <= 32'd0;
      r_q19     <= 32'd0;
      r_q17     <= 32'd0;
      r_pend    <= 3'b000;
      r_waitCnt <= 8'd0;
    end else begin
      r_state <= w_nextState;
      case (r_state)
        S_IDLE: begin
          if (iStart) begin
            r_thr  <= $signed(iThreshold);
            r_addr <= 13'd0;
          end
        end
        S_RD: r_waitCnt <= 8'd1;
        S_WAIT: begin
          r_waitCnt <= r_waitCnt + 8'd1;
          if (w_waitDone) begin
            r_q23  <= iData_from_OM_23x23;
            r_q19  <= iData_from_OM_19x19;
            r_q17  <= iData_from_OM_17x17;
            r_pend <= w_hit;
          end
        end
        S_EMIT: if (w_handshake) r_pend <= r_pend & ~w_sel;
        S_CLR: begin
          r_pend <= 3'b000;
          if (r_addr != LAST_17) r_addr <= r_addr + 13'd1;
        end
        default: ;
      endcase
    end
  end

  // Outputs are forced low for as long as reset is held, not just after the edge.
  assign oRun_PostP            = iReset_n & w_busy;
  assign oBusy                 = iReset_n & w_busy;
  assign oDone                 = iReset_n & (r_state == S_DONE);
  assign oAddr_PostP_OM_23x23  = iReset_n ? r_addr : 13'd0;
  assign oAddr_PostP_OM_19x19  = iReset_n ? r_addr : 13'd0;
  assign oAddr_PostP_OM_17x17  = iReset_n ? r_addr : 13'd0;
  assign oWrreq_PostP_OM_23x23 = iReset_n & (r_state == S_CLR) & (r_addr <= LAST_23);
  assign oWrreq_PostP_OM_19x19 = iReset_n & (r_state == S_CLR) & (r_addr <= LAST_19);
  assign oWrreq_PostP_OM_17x17 = iReset_n & (r_state == S_CLR) & (r_addr <= LAST_17);
  assign oZr_to_OM_23x23       = 32'd0;
  assign oZr_to_OM_19x19       = 32'd0;
  assign oZr_to_OM_17x17       = 32'd0;
  assign oValid                = iReset_n & w_recValid;
  assign oScale                = (iReset_n && w_recValid) ? w_recScale : 2'd0;
  assign oAddr_Hit             = (iReset_n && w_recValid) ? r_addr : 13'd0;
  assign oScore                = (iReset_n && w_recValid) ? w_recScore : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_om_scan.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_om_scan : scoreboard bench for om_scan with a RD_LAT=2 OM memory model.
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_om_scan;

  logic        iClk = 1'b0;
  logic        iReset_n;
  logic        iStart;
  logic [31:0] iThreshold;
  logic [31:0] iData_from_OM_23x23;
  logic [31:0] iData_from_OM_19x19;
  logic [31:0] iData_from_OM_17x17;
  logic        iReady;
  logic        oRun_PostP;
  logic [12:0] oAddr_PostP_OM_23x23;
  logic [12:0] oAddr_PostP_OM_19x19;
  logic [12:0] oAddr_PostP_OM_17x17;
  logic        oWrreq_PostP_OM_23x23;
  logic        oWrreq_PostP_OM_19x19;
  logic        oWrreq_PostP_OM_17x17;
  logic [31:0] oZr_to_OM_23x23;
  logic [31:0] oZr_to_OM_19x19;
  logic [31:0] oZr_to_OM_17x17;
  logic        oValid;
  logic [1:0]  oScale;
  logic [12:0] oAddr_Hit;
  logic [31:0] oScore;
  logic        oBusy;
  logic        oDone;

  always #5 iClk = ~iClk;

  om_scan dut (
    .iClk                  (iClk),
    .iReset_n              (iReset_n),
    .iStart                (iStart),
    .iThreshold            (iThreshold),
    .iData_from_OM_23x23   (iData_from_OM_23x23),
    .iData_from_OM_19x19   (iData_from_OM_19x19),
    .iData_from_OM_17x17   (iData_from_OM_17x17),
    .iReady                (iReady),
    .oRun_PostP            (oRun_PostP),
    .oAddr_PostP_OM_23x23  (oAddr_PostP_OM_23x23),
    .oAddr_PostP_OM_19x19  (oAddr_PostP_OM_19x19),
    .oAddr_PostP_OM_17x17  (oAddr_PostP_OM_17x17),
    .oWrreq_PostP_OM_23x23 (oWrreq_PostP_OM_23x23),
    .oWrreq_PostP_OM_19x19 (oWrreq_PostP_OM_19x19),
    .oWrreq_PostP_OM_17x17 (oWrreq_PostP_OM_17x17),
    .oZr_to_OM_23x23       (oZr_to_OM_23x23),
    .oZr_to_OM_19x19       (oZr_to_OM_19x19),
    .oZr_to_OM_17x17       (oZr_to_OM_17x17),
    .oValid                (oValid),
    .oScale                (oScale),
    .oAddr_Hit             (oAddr_Hit),
    .oScore                (oScore),
    .oBusy                 (oBusy),
    .oDone                 (oDone)
  );

  // OM model: a word reads as 0 once cleared during the current epoch.
  int initVal23 [8192];
  int initVal19 [8192];
  int initVal17 [8192];
  int clr23 [8192];
  int clr19 [8192];
  int clr17 [8192];
  int epoch = 1;
  logic [12:0] p23a = '0, p23b = '0, p19a = '0, p19b = '0, p17a = '0, p17b = '0;

  always @(posedge iClk) begin
    p23a <= oAddr_PostP_OM_23x23; p23b <= p23a;
    p19a <= oAddr_PostP_OM_19x19; p19b <= p19a;
    p17a <= oAddr_PostP_OM_17x17; p17b <= p17a;
    if (oWrreq_PostP_OM_23x23) clr23[oAddr_PostP_OM_23x23] <= epoch;
    if (oWrreq_PostP_OM_19x19) clr19[oAddr_PostP_OM_19x19] <= epoch;
    if (oWrreq_PostP_OM_17x17) clr17[oAddr_PostP_OM_17x17] <= epoch;
  end

  assign iData_from_OM_23x23 = (clr23[p23b] == epoch) ? 32'd0 : 32'(initVal23[p23b]);
  assign iData_from_OM_19x19 = (clr19[p19b] == epoch) ? 32'd0 : 32'(initVal19[p19b]);
  assign iData_from_OM_17x17 = (clr17[p17b] == epoch) ? 32'd0 : 32'(initVal17[p17b]);

  // Monitor: records accepted transfers and counts strobes.
  logic [1:0]  gotS  [64];
  logic [12:0] gotA  [64];
  logic [31:0] gotSc [64];
  int gotCnt = 0;
  int wr23Cnt = 0, wr19Cnt = 0, wr17Cnt = 0, bad23Cnt = 0, doneCnt = 0;

  always @(negedge iClk) begin
    if (oValid && iReady) begin
      if (gotCnt < 64) begin
        gotS[gotCnt]  <= oScale;
        gotA[gotCnt]  <= oAddr_Hit;
        gotSc[gotCnt] <= oScore;
      end
      gotCnt <= gotCnt + 1;
    end
    if (oWrreq_PostP_OM_23x23) wr23Cnt <= wr23Cnt + 1;
    if (oWrreq_PostP_OM_19x19) wr19Cnt <= wr19Cnt + 1;
    if (oWrreq_PostP_OM_17x17) wr17Cnt <= wr17Cnt + 1;
    if (oWrreq_PostP_OM_23x23 && oAddr_PostP_OM_23x23 > 13'd3599) bad23Cnt <= bad23Cnt + 1;
    if (oDone) doneCnt <= doneCnt + 1;
  end

  typedef struct {
    logic [1:0]  s;
    logic [12:0] a;
    logic [31:0] sc;
  } rec_t;
  rec_t expQ[$];
  int rdIdx = 0;
  int nVec = 0;
  int nErr = 0;

  task automatic pulseStart(input logic [31:0] thr);
    @(posedge iClk); #1;
    iStart = 1'b1; iThreshold = thr;
    @(posedge iClk); #1;
    iStart = 1'b0;
  endtask

  task automatic fillMem(input int v);
    epoch = epoch + 1;
    for (int i = 0; i < 8192; i++) begin
      initVal23[i] = v; initVal19[i] = v; initVal17[i] = v;
    end
  endtask

  task automatic waitDone(input int d0);
    int k;
    k = 0;
    while (doneCnt == d0 && k < 30000) begin
      @(negedge iClk);
      k++;
    end
    nVec++;
    if (doneCnt == d0) begin
      nErr++;
      $display("FAIL scan_timeout: got no oDone within %0d cycles, required one", k);
    end
    repeat (3) @(negedge iClk);
    nVec++;
    if ((doneCnt - d0) !== 1 || oBusy !== 1'b0) begin
      nErr++;
      $display("FAIL done_once: got %0d pulses busy=%b, required 1 pulse busy=0", doneCnt - d0, oBusy);
    end
  endtask

  task automatic checkRecords();
    rec_t e;
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      nVec++;
      if (rdIdx >= gotCnt) begin
        nErr++;
        $display("FAIL record_missing: got none, required (%0d,%0d,%0d)", e.s, e.a, $signed(e.sc));
      end else begin
        if (gotS[rdIdx] !== e.s || gotA[rdIdx] !== e.a || gotSc[rdIdx] !== e.sc) begin
          nErr++;
          $display("FAIL record: got (%0d,%0d,%0d) required (%0d,%0d,%0d)",
                   gotS[rdIdx], gotA[rdIdx], $signed(gotSc[rdIdx]), e.s, e.a, $signed(e.sc));
        end
        rdIdx++;
      end
    end
    nVec++;
    if (rdIdx !== gotCnt) begin
      nErr++;
      $display("FAIL record_extra: got %0d records total, required %0d", gotCnt, rdIdx);
      rdIdx = gotCnt;
    end
  endtask

  task automatic checkWrCounts(input int a23, input int a19, input int a17);
    nVec++;
    if ((wr23Cnt - a23) !== 3600 || (wr19Cnt - a19) !== 3920 || (wr17Cnt - a17) !== 4152) begin
      nErr++;
      $display("FAIL clr_counts: got 23=%0d 19=%0d 17=%0d, required 3600 3920 4152",
               wr23Cnt - a23, wr19Cnt - a19, wr17Cnt - a17);
    end
  endtask

  function automatic logic [167:0] allOuts();
    return {oRun_PostP, oAddr_PostP_OM_23x23, oAddr_PostP_OM_19x19, oAddr_PostP_OM_17x17,
            oWrreq_PostP_OM_23x23, oWrreq_PostP_OM_19x19, oWrreq_PostP_OM_17x17,
            oValid, oScale, oAddr_Hit, oScore, oBusy, oDone, 8'd0,
            oZr_to_OM_23x23 | oZr_to_OM_19x19 | oZr_to_OM_17x17};
  endfunction

  task automatic test_reset();
    iReset_n = 1'b0; iStart = 1'b0; iThreshold = 32'd0; iReady = 1'b1;
    repeat (3) @(negedge iClk);
    nVec++;
    if (allOuts() !== '0) begin
      nErr++;
      $display("FAIL reset_outputs: got %h, required all zero", allOuts());
    end
    @(posedge iClk); #1;
    iReset_n = 1'b1;
    @(negedge iClk);
    nVec++;
    if (oBusy !== 1'b0 || oAddr_PostP_OM_23x23 !== 13'd0 || oValid !== 1'b0) begin
      nErr++;
      $display("FAIL idle_after_reset: got busy=%b addr=%0d valid=%b, required 0 0 0",
               oBusy, oAddr_PostP_OM_23x23, oValid);
    end
  endtask

  task automatic test_zero_scan();
    int a23, a19, a17, d0, g0;
    a23 = wr23Cnt; a19 = wr19Cnt; a17 = wr17Cnt; d0 = doneCnt; g0 = gotCnt;
    pulseStart(32'd0);
    @(negedge iClk);
    nVec++;
    if (oBusy !== 1'b1 || oRun_PostP !== 1'b1 || oAddr_PostP_OM_17x17 !== 13'd0) begin
      nErr++;
      $display("FAIL start_busy: got busy=%b run=%b addr=%0d, required 1 1 0",
               oBusy, oRun_PostP, oAddr_PostP_OM_17x17);
    end
    waitDone(d0);
    checkWrCounts(a23, a19, a17);
    nVec++;
    if (gotCnt !== g0 || bad23Cnt !== 0) begin
      nErr++;
      $display("FAIL zero_scan: got %0d records, %0d bad writes, required 0 0", gotCnt - g0, bad23Cnt);
    end
    checkRecords();
  endtask

  task automatic test_hits_stall();
    logic [1:0] s0; logic [12:0] a0; logic [31:0] sc0;
    int d0, k;
    fillMem(0);
    initVal23[100] = 5; initVal19[100] = 5; initVal17[100] = 5;
    initVal23[200] = 4; initVal19[200] = 4; initVal17[200] = 4;
    initVal17[4000] = 7; initVal23[4000] = 9; initVal19[4000] = 9;
    expQ.push_back('{2'd0, 13'd100, 32'd5});
    expQ.push_back('{2'd1, 13'd100, 32'd5});
    expQ.push_back('{2'd2, 13'd100, 32'd5});
    expQ.push_back('{2'd2, 13'd4000, 32'd7});
    d0 = doneCnt;
    iReady = 1'b0;
    pulseStart(32'd4);
    k = 0;
    while (oValid !== 1'b1 && k < 2000) begin
      @(negedge iClk);
      k++;
    end
    s0 = oScale; a0 = oAddr_Hit; sc0 = oScore;
    nVec++;
    if (s0 !== 2'd0 || a0 !== 13'd100 || sc0 !== 32'd5) begin
      nErr++;
      $display("FAIL first_hit: got (%0d,%0d,%0d) valid=%b, required (0,100,5) valid=1", s0, a0, sc0, oValid);
    end
    for (int i = 0; i < 10; i++) begin
      nVec++;
      if (oValid !== 1'b1 || oScale !== s0 || oAddr_Hit !== a0 || oScore !== sc0 ||
          oWrreq_PostP_OM_23x23 !== 1'b0 || oWrreq_PostP_OM_17x17 !== 1'b0) begin
        nErr++;
        $display("FAIL stall_hold_%0d: got v=%b (%0d,%0d,%0d) wr=%b, required v=1 (%0d,%0d,%0d) wr=0",
                 i, oValid, oScale, oAddr_Hit, oScore, oWrreq_PostP_OM_23x23, s0, a0, sc0);
      end
      @(negedge iClk);
    end
    @(posedge iClk); #1;
    iReady = 1'b1;
    waitDone(d0);
    checkRecords();
    nVec++;
    if (clr23[100] !== epoch || clr19[100] !== epoch || clr17[100] !== epoch) begin
      nErr++;
      $display("FAIL clear_100: got %0d %0d %0d, required all %0d", clr23[100], clr19[100], clr17[100], epoch);
    end
    nVec++;
    if (clr17[4000] !== epoch || clr23[4000] === epoch || clr19[4000] === epoch || bad23Cnt !== 0) begin
      nErr++;
      $display("FAIL clear_4000: got 17=%0d 23=%0d 19=%0d bad=%0d, required 17 cleared only",
               clr17[4000], clr23[4000], clr19[4000], bad23Cnt);
    end
  endtask

  task automatic test_signed_restart_ignored();
    int a23, a19, a17, d0, k;
    fillMem(-5);
    initVal23[300] = -1; initVal19[300] = -1; initVal17[300] = -1;
    initVal23[301] = -2; initVal19[301] = -2; initVal17[301] = -2;
    expQ.push_back('{2'd0, 13'd300, 32'hFFFF_FFFF});
    expQ.push_back('{2'd1, 13'd300, 32'hFFFF_FFFF});
    expQ.push_back('{2'd2, 13'd300, 32'hFFFF_FFFF});
    a23 = wr23Cnt; a19 = wr19Cnt; a17 = wr17Cnt; d0 = doneCnt;
    pulseStart(32'hFFFF_FFFE);
    k = 0;
    while (oAddr_PostP_OM_23x23 !== 13'd10 && k < 1000) begin
      @(negedge iClk);
      k++;
    end
    pulseStart(32'd100);
    waitDone(d0);
    checkRecords();
    checkWrCounts(a23, a19, a17);
  endtask

  task automatic test_reset_midscan();
    int a23, k;
    fillMem(0);
    pulseStart(32'd0);
    k = 0;
    while (oAddr_PostP_OM_23x23 !== 13'd50 && k < 1000) begin
      @(negedge iClk);
      k++;
    end
    nVec++;
    if (oAddr_PostP_OM_23x23 !== 13'd50) begin
      nErr++;
      $display("FAIL reach_50: got %0d, required 50", oAddr_PostP_OM_23x23);
    end
    @(posedge iClk); #1;
    iReset_n = 1'b0;
    a23 = wr23Cnt;
    @(posedge iClk); #1;
    @(negedge iClk);
    nVec++;
    if (allOuts() !== '0 || wr23Cnt !== a23) begin
      nErr++;
      $display("FAIL midscan_reset: got %h writes=%0d, required zero 0", allOuts(), wr23Cnt - a23);
    end
    @(posedge iClk); #1;
    iReset_n = 1'b1;
    @(negedge iClk);
    nVec++;
    if (oBusy !== 1'b0 || oValid !== 1'b0 || oAddr_PostP_OM_19x19 !== 13'd0) begin
      nErr++;
      $display("FAIL post_reset_idle: got busy=%b valid=%b addr=%0d, required 0 0 0",
               oBusy, oValid, oAddr_PostP_OM_19x19);
    end
    pulseStart(32'd0);
    @(negedge iClk);
    nVec++;
    if (oBusy !== 1'b1 || oAddr_PostP_OM_23x23 !== 13'd0) begin
      nErr++;
      $display("FAIL rescan_from_0: got busy=%b addr=%0d, required 1 0", oBusy, oAddr_PostP_OM_23x23);
    end
    repeat (12) @(negedge iClk);
    nVec++;
    if (oAddr_PostP_OM_23x23 !== 13'd2) begin
      nErr++;
      $display("FAIL rescan_progress: got addr=%0d, required 2", oAddr_PostP_OM_23x23);
    end
    @(posedge iClk); #1;
    iReset_n = 1'b0;
    repeat (2) @(posedge iClk);
  endtask

  initial begin
    test_reset();
    test_zero_scan();
    test_hits_stall();
    test_signed_restart_ignored();
    test_reset_midscan();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
`default_nettype wire
